instr_fetch: RTL and testbench
==============================

INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter PC_W, default 10, SHALL set the width of program-counter and table entries.
REQ-002 Parameters TGT0..TGT3, default 0, SHALL be the reset values of jump-target table entries 0..3.
REQ-003 Clk  in  1  SHALL be the single clock; all state changes on its rising edge.
REQ-004 Reset  in  1  SHALL be synchronous, active-high reset.
REQ-005 Start  in  1  SHALL request program execution from StartAddr.
REQ-006 StartAddr  in  PC_W  SHALL give the first fetch address.
REQ-007 ImemAddr  out  PC_W  SHALL drive the address of the synchronous instruction memory, which has 1-cycle read latency.
REQ-008 ImemData  in  9  SHALL carry the word addressed by ImemAddr in the previous cycle.
REQ-009 Instruction  out  9  SHALL present the machine code to the control decoder.
REQ-010 InstValid  out  1  SHALL mark Instruction as an executing instruction.
REQ-011 ProgCtr  out  PC_W  SHALL give the address of Instruction.
REQ-012 Jump, BranchEn, Taken, Ack  in  1 each  SHALL be the decoder's jump, branch-enable and ack outputs, plus the ALU branch condition.
REQ-013 TargSel  in  2  SHALL select the jump-target table entry.
REQ-014 TblWrEn  in  1, TblIdx  in  2, TblData  in  PC_W  SHALL form the table write port.
REQ-015 Done  out  1  SHALL indicate the program has halted.

Function
REQ-016 FSM states SHALL be IDLE, PRIME, EXEC and HALT; the fetch pointer FPC SHALL drive ImemAddr directly.
REQ-017 IDLE: InstValid=0 and Done=0; when Start=1, FPC<=StartAddr and the FSM moves to PRIME.
REQ-018 PRIME: InstValid=0, ProgCtr<=FPC, FPC<=FPC+1, and the FSM moves to EXEC unconditionally.
REQ-019 EXEC: Instruction=ImemData and InstValid=1, except in a squash cycle.
REQ-020 An EXEC non-squash cycle SHALL be an executing cycle.
REQ-021 An executing cycle with no redirect and no Ack SHALL set ProgCtr<=FPC and FPC<=FPC+1.
REQ-022 Redirect SHALL occur when an executing cycle has Jump=1, or BranchEn=1 and Taken=1.
REQ-023 On redirect, FPC<=table[TargSel] and the following cycle SHALL be a squash cycle.
REQ-024 In a squash cycle: InstValid=0, ImemData ignored, ProgCtr<=FPC, FPC<=FPC+1.
REQ-025 Jump, BranchEn, Ack and Taken SHALL be ignored whenever InstValid=0.
REQ-026 Ack=1 in an executing cycle SHALL take priority over redirect: the FSM moves to HALT, FPC is held, and ProgCtr is held.
REQ-027 HALT: InstValid=0 and Done=1.
REQ-028 Start=1 in HALT SHALL behave as in IDLE: Done<=0, FPC<=StartAddr, next state PRIME.
REQ-029 Start SHALL be ignored in PRIME and EXEC.
REQ-030 FPC arithmetic SHALL be modulo 2^PC_W, so all-ones+1 wraps to 0 with no flag.
REQ-031 TblWrEn=1 SHALL write TblData to table[TblIdx] at the clock edge, in any state.
REQ-032 A redirect reading the index being written in the same cycle SHALL use the old entry.
REQ-033 Instruction SHALL be 0 whenever InstValid=0.
REQ-034 Latency: Start sampled at edge s gives first InstValid=1 in cycle s+2, with ProgCtr=StartAddr.
REQ-035 Redirect at cycle t gives the target instruction valid in cycle t+2 (one bubble).

Reset
REQ-036 Reset=1 SHALL force IDLE, FPC=0, ProgCtr=0, InstValid=0, Done=0 and table={TGT0..TGT3}, overriding Start and TblWrEn in the same cycle.
REQ-037 Reset asserted in any state, including mid-redirect or squash, SHALL abandon the operation, with IDLE outputs from the next cycle.

Verification
REQ-038 Start with StartAddr=0x010, and memory holding 0x000, 0x040, 0x1FF at 0x010-0x012 -> InstValid in cycles 2-4, ProgCtr 0x010/0x011/0x012, then Done=1 with ProgCtr held at 0x012.
REQ-039 Write table[2]=0x200, then execute a Jump with TargSel=2 at 0x005 -> next cycle InstValid=0, then ProgCtr=0x200 valid.
REQ-040 BranchEn=1 with Taken=0 -> no bubble, ProgCtr steps +1; BranchEn=1 with Taken=1 -> 1-cycle bubble, then the table target.
REQ-041 Instruction 0x1FF (Ack=1, BranchEn=1, Taken=1) -> HALT, no redirect; then Start=1 with StartAddr=0x3FF -> ProgCtr 0x3FF then 0x000 (wrap).
REQ-042 Reset asserted in a squash cycle after a jump -> next cycle IDLE, InstValid=0, ProgCtr=0, and table restored to TGT values.
REQ-043 Same-cycle TblWrEn to idx 1 (0x0AA) and Jump with TargSel=1 (old value 0x055) -> fetch 0x055; a later jump with TargSel=1 -> 0x0AA.

Source files
------------

// File: rtl/instr_fetch.sv
// Instruction fetch unit: drives a 1-cycle-latency instruction memory, presents
// instructions to the decoder, and handles jumps/branches through a 4-entry target table.
module instr_fetch #(
    parameter int unsigned      PC_W = 10,
    parameter logic [PC_W-1:0]  TGT0 = '0,
    parameter logic [PC_W-1:0]  TGT1 = '0,
    parameter logic [PC_W-1:0]  TGT2 = '0,
    parameter logic [PC_W-1:0]  TGT3 = '0
) (
    input  logic            Clk,
    input  logic            Reset,
    input  logic            Start,
    input  logic [PC_W-1:0] StartAddr,
    output logic [PC_W-1:0] ImemAddr,
    input  logic [8:0]      ImemData,
    output logic [8:0]      Instruction,
    output logic            InstValid,
    output logic [PC_W-1:0] ProgCtr,
    input  logic            Jump,
    input  logic            BranchEn,
    input  logic            Taken,
    input  logic            Ack,
    input  logic [1:0]      TargSel,
    input  logic            TblWrEn,
    input  logic [1:0]      TblIdx,
    input  logic [PC_W-1:0] TblData,
    output logic            Done
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] PRIME = 2'd1;
    localparam logic [1:0] EXEC  = 2'd2;
    localparam logic [1:0] HALT  = 2'd3;

    logic [1:0]      state;
    logic            squash;
    logic [PC_W-1:0] fpc;
    logic [PC_W-1:0] pc;
    logic [PC_W-1:0] tbl [4];
    logic            executing;
    logic            redirect;

    always_comb begin
        executing   = (state == EXEC) && !squash;
        redirect    = executing && (Jump || (BranchEn && Taken));
        InstValid   = executing;
        Instruction = executing ? ImemData : '0;
        Done        = (state == HALT);
        ImemAddr    = fpc;
        ProgCtr     = pc;
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state  <= IDLE;
            squash <= 1'b0;
            fpc    <= '0;
            pc     <= '0;
            tbl[0] <= TGT0;
            tbl[1] <= TGT1;
            tbl[2] <= TGT2;
            tbl[3] <= TGT3;
        end else begin
            // Table read below sees the pre-edge value, so a same-cycle write is not forwarded.
            if (TblWrEn) tbl[TblIdx] <= TblData;
            case (state)
                IDLE, HALT: begin
                    if (Start) begin
                        fpc   <= StartAddr;
                        state <= PRIME;
                    end
                end
                PRIME: begin
                    pc     <= fpc;
                    fpc    <= fpc + PC_W'(1);
                    squash <= 1'b0;
                    state  <= EXEC;
                end
                EXEC: begin
                    if (squash) begin
                        pc     <= fpc;
                        fpc    <= fpc + PC_W'(1);
                        squash <= 1'b0;
                    end else if (Ack) begin
                        state <= HALT;
                    end else if (redirect) begin
                        fpc    <= tbl[TargSel];
                        squash <= 1'b1;
                    end else begin
                        pc  <= fpc;
                        fpc <= fpc + PC_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch: a memory model and a tiny decoder drive the DUT;
// expected (ProgCtr, Instruction) pairs are queued and checked by a separate monitor.
module tb_instr_fetch;

    localparam int unsigned PC_W = 10;

    logic            Clk = 1'b0;
    logic            Reset, Start, TblWrEn;
    logic [PC_W-1:0] StartAddr, TblData, ImemAddr, ProgCtr;
    logic [8:0]      ImemData, Instruction;
    logic            InstValid, Done;
    logic            Jump, BranchEn, Taken, Ack;
    logic [1:0]      TargSel, TblIdx;

    logic [8:0]      mem [1024];
    logic            dec_ack, dec_jump, dec_br, dec_taken;

    typedef struct packed { logic [PC_W-1:0] pc; logic [8:0] ins; } exp_t;
    exp_t q [$];
    int n_cmp = 0;
    int n_err = 0;

    instr_fetch #(.PC_W(PC_W), .TGT0(10'h300), .TGT1(10'h055), .TGT2(10'h020), .TGT3(10'h3F0)) dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .StartAddr(StartAddr),
        .ImemAddr(ImemAddr), .ImemData(ImemData), .Instruction(Instruction),
        .InstValid(InstValid), .ProgCtr(ProgCtr), .Jump(Jump), .BranchEn(BranchEn),
        .Taken(Taken), .Ack(Ack), .TargSel(TargSel), .TblWrEn(TblWrEn),
        .TblIdx(TblIdx), .TblData(TblData), .Done(Done)
    );

    always #5 Clk = ~Clk;

    always @(posedge Clk) ImemData <= mem[ImemAddr];

    // Decoder: 0x1FF halts (ack+taken branch, sel 3), 100xxxxxx jumps, 101xxxxxx branches on bit 2.
    // While InstValid=0 every control input is driven high as noise that must be ignored.
    always_comb begin
        dec_ack   = (Instruction == 9'h1FF);
        dec_jump  = (Instruction[8:6] == 3'b100);
        dec_br    = (Instruction[8:6] == 3'b101) || dec_ack;
        dec_taken = dec_ack || Instruction[2];
        Ack       = InstValid ? dec_ack   : 1'b1;
        Jump      = InstValid ? dec_jump  : 1'b1;
        BranchEn  = InstValid ? dec_br    : 1'b1;
        Taken     = InstValid ? dec_taken : 1'b1;
        TargSel   = InstValid ? Instruction[1:0] : 2'd3;
    end

    task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge Clk) begin
        if (!Reset && InstValid) begin
            if (q.size() == 0) begin
                check("unexpected_valid_pc", 16'(ProgCtr), 16'hFFFF);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("sb_progctr", 16'(ProgCtr), 16'(e.pc));
                check("sb_instruction", 16'(Instruction), 16'(e.ins));
            end
        end
    end

    task automatic push(input logic [PC_W-1:0] pc, input logic [8:0] ins);
        exp_t e;
        e.pc  = pc;
        e.ins = ins;
        q.push_back(e);
    endtask

    task automatic start_prog(input logic [PC_W-1:0] addr);
        @(negedge Clk);
        Start     = 1'b1;
        StartAddr = addr;
        @(posedge Clk);
        #1 Start = 1'b0;
    endtask

    // Counts cycles until InstValid; a bubble-free successor is 1, a post-redirect or post-start one is 2.
    task automatic wait_valid(input string nm, input int expcyc);
        int c;
        c = 0;
        do begin
            @(negedge Clk);
            c++;
        end while (!InstValid && c < 20);
        check(nm, 16'(c), 16'(expcyc));
    endtask

    task automatic check_halted(input string nm, input logic [PC_W-1:0] pc);
        @(negedge Clk);
        check({nm, "_done"}, 16'(Done), 16'd1);
        check({nm, "_valid"}, 16'(InstValid), 16'd0);
        check({nm, "_pc"}, 16'(ProgCtr), 16'(pc));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = '0;
        mem[10'h010] = 9'h000; mem[10'h011] = 9'h040; mem[10'h012] = 9'h1FF;
        mem[10'h005] = 9'h102; mem[10'h006] = 9'h1FF; mem[10'h200] = 9'h1FF;
        mem[10'h030] = 9'h140; mem[10'h031] = 9'h147; mem[10'h3F0] = 9'h1FF;
        mem[10'h3FF] = 9'h040; mem[10'h000] = 9'h1FF;
        mem[10'h080] = 9'h101; mem[10'h055] = 9'h040; mem[10'h056] = 9'h101; mem[10'h0AA] = 9'h1FF;
        mem[10'h0C0] = 9'h100; mem[10'h0C1] = 9'h1FF;
        mem[10'h0D0] = 9'h102; mem[10'h020] = 9'h1FF;

        // Reset overrides a simultaneous Start and table write.
        Reset = 1'b1; Start = 1'b1; StartAddr = 10'h123;
        TblWrEn = 1'b1; TblIdx = 2'd0; TblData = 10'h3AB;
        repeat (3) @(posedge Clk);
        #1 Reset = 1'b0; Start = 1'b0; TblWrEn = 1'b0;
        @(negedge Clk);
        check("rst_imemaddr", 16'(ImemAddr), 16'h0);
        check("rst_valid", 16'(InstValid), 16'd0);
        check("rst_done", 16'(Done), 16'd0);
        check("rst_progctr", 16'(ProgCtr), 16'h0);
        check("rst_instruction", 16'(Instruction), 16'h0);

        // Straight-line program ending in halt.
        push(10'h010, 9'h000); push(10'h011, 9'h040); push(10'h012, 9'h1FF);
        start_prog(10'h010);
        wait_valid("t1_start_latency", 2);
        wait_valid("t1_step1", 1);
        wait_valid("t1_step2", 1);
        check_halted("t1_halt", 10'h012);

        // Table write then jump through entry 2.
        @(negedge Clk);
        TblWrEn = 1'b1; TblIdx = 2'd2; TblData = 10'h200;
        @(posedge Clk);
        #1 TblWrEn = 1'b0;
        push(10'h005, 9'h102); push(10'h200, 9'h1FF);
        start_prog(10'h005);
        wait_valid("t2_start_latency", 2);
        @(negedge Clk);
        check("t2_squash_valid", 16'(InstValid), 16'd0);
        check("t2_squash_instr", 16'(Instruction), 16'h0);
        wait_valid("t2_target", 1);
        check_halted("t2_halt", 10'h200);

        // Branch not taken (no bubble), Start ignored in EXEC, branch taken (one bubble).
        push(10'h030, 9'h140); push(10'h031, 9'h147); push(10'h3F0, 9'h1FF);
        start_prog(10'h030);
        wait_valid("t3_start_latency", 2);
        Start = 1'b1; StartAddr = 10'h2AA;
        @(posedge Clk);
        #1 Start = 1'b0;
        wait_valid("t3_not_taken", 1);
        wait_valid("t3_taken", 2);
        check_halted("t3_halt", 10'h3F0);

        // Restart from HALT at the top of the address space: fetch wraps to 0.
        push(10'h3FF, 9'h040); push(10'h000, 9'h1FF);
        start_prog(10'h3FF);
        wait_valid("t4_start_latency", 2);
        wait_valid("t4_wrap", 1);
        check_halted("t4_halt", 10'h000);

        // Same-cycle table write and jump read the old entry; the later jump sees the new one.
        push(10'h080, 9'h101); push(10'h055, 9'h040); push(10'h056, 9'h101); push(10'h0AA, 9'h1FF);
        start_prog(10'h080);
        wait_valid("t5_start_latency", 2);
        TblWrEn = 1'b1; TblIdx = 2'd1; TblData = 10'h0AA;
        @(posedge Clk);
        #1 TblWrEn = 1'b0;
        wait_valid("t5_old_target", 2);
        wait_valid("t5_step", 1);
        wait_valid("t5_new_target", 2);
        check_halted("t5_halt", 10'h0AA);

        // Reset during the squash cycle, then confirm the table entry 2 is back to TGT2.
        push(10'h0C0, 9'h100);
        start_prog(10'h0C0);
        wait_valid("t6_start_latency", 2);
        @(negedge Clk);
        check("t6_squash_valid", 16'(InstValid), 16'd0);
        Reset = 1'b1;
        @(posedge Clk);
        #1 Reset = 1'b0;
        @(negedge Clk);
        check("t6_rst_valid", 16'(InstValid), 16'd0);
        check("t6_rst_progctr", 16'(ProgCtr), 16'h0);
        check("t6_rst_imemaddr", 16'(ImemAddr), 16'h0);
        check("t6_rst_done", 16'(Done), 16'd0);
        push(10'h0D0, 9'h102); push(10'h020, 9'h1FF);
        start_prog(10'h0D0);
        wait_valid("t6_start_latency2", 2);
        wait_valid("t6_restored_target", 2);
        check_halted("t6_halt", 10'h020);

        check("queue_drained", 16'(q.size()), 16'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
